// File: rtl/jtcontra_rom_sched.sv
// Four-slot SDRAM read scheduler. Slots are granted round-robin. Each
// transaction runs through request/ack and data phases, and the result is
// returned as a one-cycle slot_ok pulse. The data phase is bounded by a
// timeout, and the downloading input can abort a transaction at any time.
module jtcontra_rom_sched #(
  parameter int AW   = 22,
  parameter int TOUT = 63
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    slot_req,
  input  logic [AW-1:0] slot0_addr,
  input  logic [AW-1:0] slot1_addr,
  input  logic [AW-1:0] slot2_addr,
  input  logic [AW-1:0] slot3_addr,
  output logic [3:0]    slot_ok,
  output logic [31:0]   dout,
  output logic          sdram_req,
  output logic [AW-1:0] sdram_addr,
  input  logic          sdram_ack,
  input  logic          data_rdy,
  input  logic [31:0]   data_read,
  input  logic          downloading,
  output logic          refresh_en,
  output logic          tout_err
);

  localparam int CW = $clog2(TOUT + 1);

  typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_DATA} state_t;

  state_t          state_q, state_d;
  logic [1:0]      last_grant_q, last_grant_d;
  logic [1:0]      grant_q, grant_d;
  logic            sdram_req_q, sdram_req_d;
  logic [AW-1:0]   sdram_addr_q, sdram_addr_d;
  logic [31:0]     dout_q, dout_d;
  logic [3:0]      slot_ok_q, slot_ok_d;
  logic            tout_err_q, tout_err_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [AW-1:0]   slot_addr [4];
  logic [3:0]      eligible;
  logic            found;
  logic [1:0]      pick;
  logic            timeout_hit;

  assign slot_addr[0] = slot0_addr;
  assign slot_addr[1] = slot1_addr;
  assign slot_addr[2] = slot2_addr;
  assign slot_addr[3] = slot3_addr;

  // A slot that is receiving its slot_ok pulse may still show its old
  // request, so it is excluded for that one cycle to avoid re-serving it.
  assign eligible    = slot_req & ~slot_ok_q;
  assign timeout_hit = (cnt_q == CW'(TOUT - 1));

  // Round-robin search that starts one past the last granted slot
  always_comb begin
    found = 1'b0;
    pick  = last_grant_q;
    for (int i = 1; i <= 4; i++) begin
      if (!found && eligible[last_grant_q + 2'(i)]) begin
        found = 1'b1;
        pick  = last_grant_q + 2'(i);
      end
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 2'd3;
      grant_q      <= 2'd0;
      sdram_req_q  <= 1'b0;
      sdram_addr_q <= '0;
      dout_q       <= '0;
      slot_ok_q    <= '0;
      tout_err_q   <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      sdram_req_q  <= sdram_req_d;
      sdram_addr_q <= sdram_addr_d;
      dout_q       <= dout_d;
      slot_ok_q    <= slot_ok_d;
      tout_err_q   <= tout_err_d;
      cnt_q        <= cnt_d;
    end
  end

  // Next-state logic; downloading overrides every state
  always_comb begin
    state_d = state_q;
    if (downloading) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:      if (found) state_d = WAIT_ACK;
        WAIT_ACK:  if (sdram_ack) state_d = WAIT_DATA;
        WAIT_DATA: if (data_rdy || timeout_hit) state_d = IDLE;
        default:   state_d = IDLE;
      endcase
    end
  end

  // Per-state register updates: grant latch, handshake, data capture, timeout
  always_comb begin
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    sdram_req_d  = sdram_req_q;
    sdram_addr_d = sdram_addr_q;
    dout_d       = dout_q;
    slot_ok_d    = '0;
    tout_err_d   = tout_err_q;
    cnt_d        = cnt_q;
    if (downloading) begin
      sdram_req_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (found) begin
            grant_d      = pick;
            last_grant_d = pick;
            sdram_addr_d = slot_addr[pick];
            sdram_req_d  = 1'b1;
          end
        end
        WAIT_ACK: begin
          if (sdram_ack) begin
            sdram_req_d = 1'b0;
            cnt_d       = '0;
          end
        end
        WAIT_DATA: begin
          cnt_d = cnt_q + 1'b1;
          if (data_rdy) begin
            dout_d             = data_read;
            slot_ok_d[grant_q] = slot_req[grant_q];
          end else if (timeout_hit) begin
            tout_err_d = 1'b1;
          end
        end
        default: begin
          sdram_req_d = 1'b0;
        end
      endcase
    end
  end

  // Output drive; refresh is allowed whenever the bus is idle and unwanted
  always_comb begin
    sdram_req  = sdram_req_q;
    sdram_addr = sdram_addr_q;
    dout       = dout_q;
    slot_ok    = slot_ok_q;
    tout_err   = tout_err_q;
    refresh_en = (state_q == IDLE) && ((slot_req == 4'b0000) || downloading);
  end

endmodule

// File: tb/tb_jtcontra_rom_sched.sv
// Testbench for jtcontra_rom_sched. The bench acts as both the requesters
// and the SDRAM. A transaction-level model predicts which slot is granted
// next, the address that should appear, and the data and slot_ok each
// transaction returns.
module tb_jtcontra_rom_sched;

  localparam int AW   = 22;
  localparam int TOUT = 63;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    slot_req;
  logic [AW-1:0] a0, a1, a2, a3;
  logic [3:0]    slot_ok;
  logic [31:0]   dout;
  logic          sdram_req;
  logic [AW-1:0] sdram_addr;
  logic          sdram_ack;
  logic          data_rdy;
  logic [31:0]   data_read;
  logic          downloading;
  logic          refresh_en;
  logic          tout_err;

  int            total_checks = 0;
  int            bad_checks   = 0;
  logic [3:0]    req_mask;
  logic [AW-1:0] slot_addr [4];
  int            model_last;
  int            s;

  jtcontra_rom_sched #(.AW(AW), .TOUT(TOUT)) dut (
    .clk(clk), .rst(rst), .slot_req(slot_req),
    .slot0_addr(a0), .slot1_addr(a1), .slot2_addr(a2), .slot3_addr(a3),
    .slot_ok(slot_ok), .dout(dout), .sdram_req(sdram_req),
    .sdram_addr(sdram_addr), .sdram_ack(sdram_ack), .data_rdy(data_rdy),
    .data_read(data_read), .downloading(downloading),
    .refresh_en(refresh_en), .tout_err(tout_err)
  );

  always #5 clk = ~clk;

  // Safety net so a stuck design can never hang the run
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_checks++;
    if (got !== exp) begin
      bad_checks++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus();
    slot_req = req_mask;
    a0 = slot_addr[0];
    a1 = slot_addr[1];
    a2 = slot_addr[2];
    a3 = slot_addr[3];
  endtask

  // Give each slot a random address whose low bits identify the slot
  function automatic logic [AW-1:0] randAddr(input int k);
    logic [33:0] raw;
    raw = {$urandom, 2'(k)};
    return raw[AW-1:0];
  endfunction

  // Spec rule: search from (last grant + 1) mod 4 for the first pending slot
  function automatic int nextGrant();
    for (int k = 1; k <= 4; k++)
      if (req_mask[(model_last + k) % 4]) return (model_last + k) % 4;
    return -1;
  endfunction

  // New requesters may appear; a slot's address changes only while it is idle
  task automatic raiseRandom();
    logic [3:0] add;
    add = 4'($urandom_range(0, 15));
    if ((req_mask | add) == 4'b0000) add[$urandom_range(0, 3)] = 1'b1;
    for (int k = 0; k < 4; k++)
      if (add[k] && !req_mask[k]) begin
        slot_addr[k] = randAddr(k);
        req_mask[k]  = 1'b1;
      end
  endtask

  task automatic doReset();
    rst = 1'b1;
    req_mask = 4'b0000;
    downloading = 1'b0;
    sdram_ack = 1'b0;
    data_rdy = 1'b0;
    data_read = '0;
    applyStimulus();
    repeat (2) @(negedge clk);
    checkOutput("rst_sdram_req", sdram_req, 1'b0);
    checkOutput("rst_sdram_addr", sdram_addr, '0);
    checkOutput("rst_slot_ok", slot_ok, 4'b0000);
    checkOutput("rst_dout", dout, 32'h0);
    checkOutput("rst_tout_err", tout_err, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_refresh_en", refresh_en, 1'b1);
    model_last = 3;
  endtask

  // Wait for a grant, check the granted address against the model, and
  // report the slot the DUT actually chose (its address low bits)
  task automatic waitGrant(output int obs);
    int n;
    int exp_slot;
    n = 0;
    obs = -1;
    while (sdram_req !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    checkOutput("grant_seen", sdram_req, 1'b1);
    if (sdram_req !== 1'b1) return;
    exp_slot = nextGrant();
    checkOutput("grant_pending", exp_slot >= 0, 1'b1);
    if (exp_slot < 0) return;
    checkOutput("grant_addr", sdram_addr, slot_addr[exp_slot]);
    model_last = exp_slot;
    obs = int'(sdram_addr[1:0]);
  endtask

  // Play the SDRAM side of one transaction. Stray data_rdy pulses are driven
  // while waiting for ack, and stray acks while waiting for data; both must
  // be ignored.
  task automatic memTransaction(input int ack_lat, input int data_lat, input bit drop_it,
                                input bit keep_all, input bit add_rand,
                                input logic [31:0] rd_data, output int obs);
    int slot;
    waitGrant(obs);
    if (obs < 0) return;
    slot = model_last;
    for (int i = 0; i < ack_lat; i++) begin
      data_rdy  = 1'($urandom_range(0, 1));
      data_read = $urandom;
      @(negedge clk);
      checkOutput("req_held", sdram_req, 1'b1);
    end
    data_rdy  = 1'b0;
    sdram_ack = 1'b1;
    @(negedge clk);
    sdram_ack = 1'b0;
    checkOutput("req_cleared", sdram_req, 1'b0);
    for (int i = 0; i < data_lat; i++) begin
      sdram_ack = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    sdram_ack = 1'b0;
    if (drop_it) begin
      req_mask[slot] = 1'b0;
      applyStimulus();
    end
    data_read = rd_data;
    data_rdy  = 1'b1;
    @(negedge clk);
    data_rdy  = 1'b0;
    data_read = $urandom;
    checkOutput("slot_ok", slot_ok, drop_it ? 4'b0000 : (4'b0001 << slot));
    checkOutput("dout", dout, rd_data);
    checkOutput("idle_gap", sdram_req, 1'b0);
    if (!keep_all) req_mask[slot] = 1'b0;
    if (add_rand) raiseRandom();
    applyStimulus();
    @(negedge clk);
    checkOutput("ok_one_cycle", slot_ok, 4'b0000);
  endtask

  initial begin
    for (int k = 0; k < 4; k++) slot_addr[k] = '0;
    doReset();

    // Fairness: all four slots held, zero-latency memory
    for (int k = 0; k < 4; k++) slot_addr[k] = randAddr(k);
    req_mask = 4'b1111;
    applyStimulus();
    for (int i = 0; i < 12; i++) begin
      memTransaction(0, 0, 1'b0, 1'b1, 1'b0, $urandom, s);
      checkOutput("rr_order", s, i % 4);
    end
    for (int i = 0; i < 4; i++) memTransaction(0, 0, 1'b0, 1'b0, 1'b0, $urandom, s);

    // Withdrawn request: slot 1 drops during the data phase, slot 2 is next
    slot_addr[1] = randAddr(1);
    slot_addr[2] = randAddr(2);
    req_mask = 4'b0110;
    applyStimulus();
    memTransaction(1, 2, 1'b1, 1'b0, 1'b0, 32'h1234_5678, s);
    checkOutput("withdraw_slot", s, 1);
    memTransaction(0, 1, 1'b0, 1'b0, 1'b0, $urandom, s);
    checkOutput("after_withdraw", s, 2);

    // Single request on slot 3 with fixed address and data
    slot_addr[3] = 22'h00100;
    req_mask = 4'b1000;
    applyStimulus();
    memTransaction(2, 3, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, s);
    checkOutput("single_addr", sdram_addr, 22'h00100);

    // Randomized traffic against the model, then drain
    raiseRandom();
    applyStimulus();
    for (int i = 0; i < 40; i++)
      memTransaction($urandom_range(0, 4), $urandom_range(0, 5),
                     ($urandom_range(0, 5) == 0), 1'b0, 1'b1, $urandom, s);
    for (int g = 0; g < 8 && req_mask != 4'b0000; g++)
      memTransaction(1, 1, 1'b0, 1'b0, 1'b0, $urandom, s);

    // Timeout: ack but no data; tout_err sets after TOUT data-phase cycles
    slot_addr[2] = randAddr(2);
    req_mask = 4'b0100;
    applyStimulus();
    waitGrant(s);
    sdram_ack = 1'b1;
    @(negedge clk);
    sdram_ack = 1'b0;
    repeat (TOUT - 1) @(negedge clk);
    checkOutput("tout_early", tout_err, 1'b0);
    @(negedge clk);
    checkOutput("tout_set", tout_err, 1'b1);
    checkOutput("tout_no_ok", slot_ok, 4'b0000);
    checkOutput("tout_idle_req", sdram_req, 1'b0);
    checkOutput("tout_refresh", refresh_en, 1'b0);
    memTransaction(1, 1, 1'b0, 1'b0, 1'b0, 32'hCAFE_F00D, s);
    checkOutput("tout_sticky", tout_err, 1'b1);

    // Download abort during the ack phase, then resume in round-robin order
    slot_addr[0] = randAddr(0);
    slot_addr[2] = randAddr(2);
    req_mask = 4'b0101;
    applyStimulus();
    waitGrant(s);
    checkOutput("abort_grant", s, 0);
    downloading = 1'b1;
    @(negedge clk);
    checkOutput("abort_req", sdram_req, 1'b0);
    checkOutput("abort_refresh", refresh_en, 1'b1);
    checkOutput("abort_no_ok", slot_ok, 4'b0000);
    sdram_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      sdram_ack = 1'b0;
      checkOutput("dl_no_grant", sdram_req, 1'b0);
    end
    downloading = 1'b0;
    memTransaction(1, 1, 1'b0, 1'b0, 1'b0, $urandom, s);
    checkOutput("resume_first", s, 2);
    memTransaction(1, 1, 1'b0, 1'b0, 1'b0, $urandom, s);
    checkOutput("resume_second", s, 0);

    // Reset in the data phase abandons the transaction; late data is ignored
    slot_addr[3] = randAddr(3);
    req_mask = 4'b1000;
    applyStimulus();
    waitGrant(s);
    sdram_ack = 1'b1;
    @(negedge clk);
    sdram_ack = 1'b0;
    rst = 1'b1;
    req_mask = 4'b0000;
    applyStimulus();
    @(negedge clk);
    rst = 1'b0;
    data_read = 32'hBAD0_BAD0;
    data_rdy = 1'b1;
    @(negedge clk);
    data_rdy = 1'b0;
    checkOutput("midrst_no_ok", slot_ok, 4'b0000);
    @(negedge clk);
    checkOutput("midrst_dout", dout, 32'h0);
    checkOutput("midrst_req", sdram_req, 1'b0);
    checkOutput("midrst_addr", sdram_addr, '0);
    checkOutput("midrst_tout", tout_err, 1'b0);
    checkOutput("midrst_refresh", refresh_en, 1'b1);

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
